muxs_rr: RTL and testbench

MUXS_RR -- requirements
Module: muxs_rr

---
 rtl/muxs_pkg.sv | 21 ++
 rtl/rr_pick8.sv | 30 +++
 rtl/muxs_rr.sv | 78 +++++++
 tb/tb_muxs_rr.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/muxs_pkg.sv
// Shared constants, FSM state type and pointer helper for the 8-lane
// round-robin multiplexer slice.
package muxs_pkg;

    localparam int LANES = 8;
    localparam int SEL_W = 3;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // Advance a lane index by one, wrapping the last lane back to lane 0.
    function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] p);
        if (p == SEL_W'(LANES - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin picker: finds the first requesting lane
// starting at ptr and searching upward with wrap-around.
module rr_pick8
    import muxs_pkg::*;
(
    input  logic [LANES-1:0] in_valid,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] g,
    output logic             any_valid
);

    logic [SEL_W-1:0] idx;
    logic             found;

    // Walk the lanes in priority order beginning at ptr; the first hit wins.
    always_comb begin
        g         = '0;
        idx       = '0;
        found     = 1'b0;
        any_valid = |in_valid;
        for (int i = 0; i < LANES; i++) begin
            idx = ptr + SEL_W'(i);
            if (!found && in_valid[idx]) begin
                g     = idx;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/muxs_rr.sv
// 8-lane round-robin multiplexer with a one-entry output register.
// The lane index of the held word is presented on o_sel for a downstream
// demultiplexer. Defining MUXS_RR_STATS_EN adds a saturating 16-bit
// transfer counter output xfer_cnt.
module muxs_rr
    import muxs_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [LANES-1:0]       in_valid,
    input  logic [LANES*WIDTH-1:0] in_data,
    output logic [LANES-1:0]       in_ready,
    output logic                   o_valid,
    output logic [WIDTH-1:0]       o_data,
    output logic [SEL_W-1:0]       o_sel,
    input  logic                   o_ready
`ifdef MUXS_RR_STATS_EN
    ,
    output logic [15:0]            xfer_cnt
`endif
);

    state_t           state;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] g;
    logic             any_valid;
    logic             load;

    rr_pick8 u_pick (
        .in_valid  (in_valid),
        .ptr       (ptr),
        .g         (g),
        .any_valid (any_valid)
    );

    assign o_valid = (state == FULL);

    // Load whenever the output slot is free or being drained this cycle;
    // reset blocks any acceptance so no handshake completes while it is high.
    always_comb begin
        load     = (!o_valid || o_ready) && any_valid && !rst;
        in_ready = '0;
        if (load) begin
            in_ready = LANES'(1) << g;
        end
    end

    // Output register FSM: EMPTY/FULL, with the pointer moving only on load.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= EMPTY;
            o_data <= '0;
            o_sel  <= '0;
            ptr    <= '0;
        end else if (load) begin
            state  <= FULL;
            o_data <= in_data[int'(g)*WIDTH +: WIDTH];
            o_sel  <= g;
            ptr    <= next_ptr(g);
        end else if (o_valid && o_ready) begin
            state  <= EMPTY;
        end
    end

`ifdef MUXS_RR_STATS_EN
    // Count completed output handshakes, sticking at the top value.
    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_cnt <= '0;
        end else if (o_valid && o_ready && (xfer_cnt != 16'hFFFF)) begin
            xfer_cnt <= xfer_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_muxs_rr.sv
// Self-checking bench for muxs_rr: directed scenarios followed by random
// traffic, all compared against a lane/queue-level reference model.
module tb_muxs_rr;

    localparam int WIDTH = 8;

    logic        clk;
    logic        rst;
    logic [7:0]  in_valid;
    logic [63:0] in_data;
    logic [7:0]  in_ready;
    logic        o_valid;
    logic [7:0]  o_data;
    logic [2:0]  o_sel;
    logic        o_ready;
`ifdef MUXS_RR_STATS_EN
    logic [15:0] xfer_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit       mValid;
    int       mData;
    int       mSel;
    int       mPtr;
    int       mCnt;

    muxs_rr #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .o_valid  (o_valid),
        .o_data   (o_data),
        .o_sel    (o_sel),
        .o_ready  (o_ready)
`ifdef MUXS_RR_STATS_EN
        ,
        .xfer_cnt (xfer_cnt)
`endif
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison point
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, check the handshake before the edge and
    // the registered outputs after it, advancing the model alongside.
    task automatic applyStimulus(input logic [7:0] v, input logic [63:0] d,
                                 input logic rdy, input logic r);
        int  g;
        bit  ld;
        logic [7:0] expReady;
        @(negedge clk);
        in_valid = v;
        in_data  = d;
        o_ready  = rdy;
        rst      = r;
        #1;
        ld = !r && (!mValid || rdy) && (v != 8'h00);
        g  = 0;
        if (ld) begin
            for (int k = 7; k >= 0; k--) begin
                if (v[(mPtr + k) % 8]) g = (mPtr + k) % 8;
            end
        end
        expReady = ld ? (8'h01 << g) : 8'h00;
        checkOutput("in_ready", 64'(in_ready), 64'(expReady));
        @(posedge clk);
        #1;
        if (r) begin
            mValid = 0; mData = 0; mSel = 0; mPtr = 0; mCnt = 0;
        end else begin
            if (mValid && rdy && mCnt < 65535) mCnt++;
            if (ld) begin
                mValid = 1;
                mData  = int'(d[g*8 +: 8]);
                mSel   = g;
                mPtr   = (g + 1) % 8;
            end else if (mValid && rdy) begin
                mValid = 0;
            end
        end
        checkOutput("o_valid", 64'(o_valid), 64'(mValid));
        checkOutput("o_data", 64'(o_data), 64'(mData));
        checkOutput("o_sel", 64'(o_sel), 64'(mSel));
`ifdef MUXS_RR_STATS_EN
        checkOutput("xfer_cnt", 64'(xfer_cnt), 64'(mCnt));
`endif
    endtask

    logic [63:0] rotData;
    logic [63:0] rndData;

    initial begin
        in_valid = '0;
        in_data  = '0;
        o_ready  = 1'b0;
        rst      = 1'b1;
        mValid = 0; mData = 0; mSel = 0; mPtr = 0; mCnt = 0;
        for (int i = 0; i < 8; i++) rotData[i*8 +: 8] = 8'(i * 16 + 1);

        // Reset for two cycles with every lane requesting
        applyStimulus(8'hFF, rotData, 1'b1, 1'b1);
        applyStimulus(8'hFF, rotData, 1'b1, 1'b1);
        checkOutput("rst_in_ready", 64'(in_ready), 64'h0);
        checkOutput("rst_o_valid", 64'(o_valid), 64'h0);
        checkOutput("rst_o_sel", 64'(o_sel), 64'h0);

        // Rotation: first cycle after release loads lane 0, then 1..7,0,1
        for (int i = 0; i < 10; i++) begin
            applyStimulus(8'hFF, rotData, 1'b1, 1'b0);
            checkOutput("rot_sel", 64'(o_sel), 64'(i % 8));
            checkOutput("rot_data", 64'(o_data), 64'((i % 8) * 16 + 1));
            checkOutput("rot_valid", 64'(o_valid), 64'h1);
        end

        // Drain, then backpressure with lane 3 held and lane 5 waiting
        applyStimulus(8'h00, 64'h0, 1'b1, 1'b0);
        applyStimulus(8'h08, 64'h0000_0000_A500_0000, 1'b0, 1'b0);
        checkOutput("bp_sel3", 64'(o_sel), 64'h3);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(8'h20, 64'h0000_5C00_0000_0000, 1'b0, 1'b0);
            checkOutput("bp_hold_data", 64'(o_data), 64'hA5);
            checkOutput("bp_hold_sel", 64'(o_sel), 64'h3);
        end
        applyStimulus(8'h20, 64'h0000_5C00_0000_0000, 1'b1, 1'b0);
        checkOutput("bp_load5_sel", 64'(o_sel), 64'h5);
        checkOutput("bp_load5_data", 64'(o_data), 64'h5C);

        // Skip and wrap: ptr now 6, lanes 1 and 6 requesting
        for (int i = 0; i < 8; i++) rndData[i*8 +: 8] = 8'(8'hC0 + i);
        applyStimulus(8'h42, rndData, 1'b1, 1'b0);
        checkOutput("wrap_g6a", 64'(o_sel), 64'h6);
        applyStimulus(8'h42, rndData, 1'b1, 1'b0);
        checkOutput("wrap_g1", 64'(o_sel), 64'h1);
        applyStimulus(8'h42, rndData, 1'b1, 1'b0);
        checkOutput("wrap_g6b", 64'(o_sel), 64'h6);

        // Mid-operation reset while FULL and stalled
        applyStimulus(8'h10, rndData, 1'b0, 1'b0);
        applyStimulus(8'h10, rndData, 1'b0, 1'b1);
        checkOutput("midrst_valid", 64'(o_valid), 64'h0);
`ifdef MUXS_RR_STATS_EN
        checkOutput("midrst_cnt", 64'(xfer_cnt), 64'h0);
`endif

        // Random traffic, including a lone lane and occasional reset
        for (int i = 0; i < 400; i++) begin
            logic [7:0] v;
            for (int k = 0; k < 8; k++) rndData[k*8 +: 8] = 8'($urandom);
            case ($urandom_range(0, 3))
                0:       v = 8'h01 << $urandom_range(0, 7);
                1:       v = 8'h00;
                default: v = 8'($urandom);
            endcase
            applyStimulus(v, rndData, 1'($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 49) == 0));
        end

`ifdef MUXS_RR_STATS_EN
        // Saturation of the transfer counter
        applyStimulus(8'h00, 64'h0, 1'b1, 1'b1);
        for (int i = 0; i < 65542; i++) begin
            applyStimulus(8'hFF, rotData, 1'b1, 1'b0);
        end
        checkOutput("cnt_sat", 64'(xfer_cnt), 64'hFFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
